// File: rtl/uart_port_arbiter.sv
// Two-port round-robin front end for the shared byte UART engine.
// One byte operation (write or read) is sequenced at a time, with a timeout on the engine's done pulse.
module uart_port_arbiter #(
  parameter int TIMEOUT = 1000000,
  parameter int CNT_W   = 32
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       req0,
  input  logic       we0,
  input  logic [7:0] wdata0,
  output logic       ack0,
  output logic [7:0] rdata0,
  output logic       err0,
  input  logic       req1,
  input  logic       we1,
  input  logic [7:0] wdata1,
  output logic       ack1,
  output logic [7:0] rdata1,
  output logic       err1,
  input  logic       u_ready,
  output logic [7:0] t_data,
  output logic       t_valid,
  output logic       r_valid,
  input  logic       tx_done,
  input  logic       rx_done,
  input  logic [7:0] r_data,
  output logic       busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic             last_grant;
  logic             gnt;
  logic             op_we;
  logic [CNT_W-1:0] counter;

  // A tie goes to the port that was not served last; a lone requester always wins.
  logic pick;
  logic pick_we;
  logic done_hit;

  assign pick     = (req0 && req1) ? ~last_grant : req1;
  assign pick_we  = pick ? we1 : we0;
  assign done_hit = op_we ? tx_done : rx_done;
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      gnt        <= 1'b0;
      op_we      <= 1'b0;
      counter    <= '0;
      t_data     <= 8'h00;
      t_valid    <= 1'b0;
      r_valid    <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      err0       <= 1'b0;
      err1       <= 1'b0;
      rdata0     <= 8'h00;
      rdata1     <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          if (u_ready && (req0 || req1)) begin
            gnt        <= pick;
            last_grant <= pick;
            op_we      <= pick_we;
            t_data     <= pick ? wdata1 : wdata0;
            // Strobe is registered here so it is high for exactly the ISSUE cycle.
            t_valid    <= pick_we;
            r_valid    <= ~pick_we;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          t_valid <= 1'b0;
          r_valid <= 1'b0;
          counter <= '0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          // A matching done wins over a timeout landing on the same cycle.
          if (done_hit) begin
            state <= S_RESP;
            ack0  <= ~gnt;
            ack1  <= gnt;
            err0  <= 1'b0;
            err1  <= 1'b0;
            if (!op_we) begin
              if (gnt) rdata1 <= r_data;
              else     rdata0 <= r_data;
            end
          end else if (counter == LAST_CNT) begin
            state <= S_RESP;
            ack0  <= ~gnt;
            ack1  <= gnt;
            err0  <= ~gnt;
            err1  <= gnt;
            if (!op_we) begin
              if (gnt) rdata1 <= 8'h00;
              else     rdata0 <= 8'h00;
            end
          end else begin
            counter <= counter + 1'b1;
          end
        end
        S_RESP: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          err0  <= 1'b0;
          err1  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_port_arbiter.sv
// Directed bench for uart_port_arbiter: writes, reads, round-robin ties, u_ready gating, timeout and reset abort.
module tb_uart_port_arbiter;

  logic       clk;
  logic       rstn;
  logic       req0, we0, req1, we1;
  logic [7:0] wdata0, wdata1;
  logic       ack0, ack1, err0, err1;
  logic [7:0] rdata0, rdata1;
  logic       u_ready;
  logic [7:0] t_data;
  logic       t_valid, r_valid;
  logic       tx_done, rx_done;
  logic [7:0] r_data;
  logic       busy;

  int checks = 0;
  int fails  = 0;

  int tv_n = 0, rv_n = 0, ack0_n = 0, ack1_n = 0;

  uart_port_arbiter #(.TIMEOUT(16), .CNT_W(8)) dut (
    .clk(clk), .rstn(rstn),
    .req0(req0), .we0(we0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0), .err0(err0),
    .req1(req1), .we1(we1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1), .err1(err1),
    .u_ready(u_ready), .t_data(t_data), .t_valid(t_valid), .r_valid(r_valid),
    .tx_done(tx_done), .rx_done(rx_done), .r_data(r_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters observed mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (t_valid) tv_n++;
    if (r_valid) rv_n++;
    if (ack0)    ack0_n++;
    if (ack1)    ack1_n++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; req0 = 0; we0 = 0; wdata0 = 0; req1 = 0; we1 = 0; wdata1 = 0;
    u_ready = 0; tx_done = 0; rx_done = 0; r_data = 0;
    tick(); tick();
    checks++;
    if ({ack0, ack1, err0, err1, t_valid, r_valid, busy} !== 7'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b expected 0000000", {ack0, ack1, err0, err1, t_valid, r_valid, busy});
    end
    checks++;
    if ({rdata0, rdata1, t_data} !== 24'h0) begin
      fails++;
      $display("FAIL reset_data: got %h expected 000000", {rdata0, rdata1, t_data});
    end
    rstn = 1'b1; u_ready = 1'b1;
    tick();
  endtask

  task automatic test_write_port0();
    int tv0, a1;
    tv0 = tv_n; a1 = ack1_n;
    req0 = 1; we0 = 1; wdata0 = 8'h41;
    tick();
    checks++;
    if ({t_valid, r_valid, busy, t_data} !== {3'b101, 8'h41}) begin
      fails++;
      $display("FAIL wr_strobe: got tv=%b rv=%b busy=%b data=%h expected 1 0 1 41", t_valid, r_valid, busy, t_data);
    end
    wdata0 = 8'hFF;
    tick();
    checks++;
    if (t_valid !== 1'b0) begin
      fails++;
      $display("FAIL wr_strobe_len: got t_valid=%b expected 0", t_valid);
    end
    tick();
    rx_done = 1; r_data = 8'h99;
    tick();
    rx_done = 0; r_data = 8'h00;
    checks++;
    if ({ack0, busy} !== 2'b01) begin
      fails++;
      $display("FAIL wr_ignore_rx: got ack0=%b busy=%b expected 0 1", ack0, busy);
    end
    tick(); tick();
    tx_done = 1;
    tick();
    tx_done = 0;
    checks++;
    if ({ack0, err0, ack1, rdata0} !== {3'b100, 8'h00}) begin
      fails++;
      $display("FAIL wr_ack: got ack0=%b err0=%b ack1=%b rdata0=%h expected 1 0 0 00", ack0, err0, ack1, rdata0);
    end
    req0 = 0;
    tick();
    checks++;
    if ({ack0, busy} !== 2'b00) begin
      fails++;
      $display("FAIL wr_idle: got ack0=%b busy=%b expected 0 0", ack0, busy);
    end
    checks++;
    if ((tv_n - tv0) !== 1 || (ack1_n - a1) !== 0) begin
      fails++;
      $display("FAIL wr_counts: got strobes=%0d ack1s=%0d expected 1 0", tv_n - tv0, ack1_n - a1);
    end
  endtask

  task automatic test_read_port1();
    int rv0;
    rv0 = rv_n;
    req1 = 1; we1 = 0; wdata1 = 8'h00;
    tick();
    checks++;
    if ({r_valid, t_valid} !== 2'b10) begin
      fails++;
      $display("FAIL rd_strobe: got rv=%b tv=%b expected 1 0", r_valid, t_valid);
    end
    tick(); tick();
    rx_done = 1; r_data = 8'h5A;
    tick();
    rx_done = 0; r_data = 8'h00;
    checks++;
    if ({ack1, err1, ack0, rdata1} !== {3'b100, 8'h5A}) begin
      fails++;
      $display("FAIL rd_ack: got ack1=%b err1=%b ack0=%b rdata1=%h expected 1 0 0 5a", ack1, err1, ack0, rdata1);
    end
    req1 = 0;
    tick();
    checks++;
    if (ack1 !== 1'b0 || (rv_n - rv0) !== 1) begin
      fails++;
      $display("FAIL rd_done: got ack1=%b strobes=%0d expected 0 1", ack1, rv_n - rv0);
    end
  endtask

  task automatic test_u_ready_gate();
    logic bad;
    bad = 0;
    u_ready = 0; req0 = 1; we0 = 1; wdata0 = 8'h33;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (t_valid || r_valid || busy) bad = 1;
    end
    checks++;
    if (bad !== 1'b0) begin
      fails++;
      $display("FAIL ready_hold: got activity=%b expected 0", bad);
    end
    u_ready = 1;
    tick();
    checks++;
    if ({t_valid, t_data} !== {1'b1, 8'h33}) begin
      fails++;
      $display("FAIL ready_go: got tv=%b data=%h expected 1 33", t_valid, t_data);
    end
    tick();
    tx_done = 1;
    tick();
    tx_done = 0;
    checks++;
    if (ack0 !== 1'b1) begin
      fails++;
      $display("FAIL ready_ack: got ack0=%b expected 1", ack0);
    end
    req0 = 0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_data;
    int         exp_port;
    rstn = 0;
    tick();
    rstn = 1;
    req0 = 1; we0 = 1; wdata0 = 8'hA0;
    req1 = 1; we1 = 1; wdata1 = 8'hB1;
    for (int k = 0; k < 4; k++) begin
      exp_port = k % 2;
      exp_data = (exp_port == 0) ? 8'hA0 : 8'hB1;
      tick();
      checks++;
      if ({t_valid, busy, t_data} !== {2'b11, exp_data}) begin
        fails++;
        $display("FAIL rr_grant%0d: got tv=%b busy=%b data=%h expected 1 1 %h", k, t_valid, busy, t_data, exp_data);
      end
      tick();
      tx_done = 1;
      tick();
      tx_done = 0;
      checks++;
      if ({ack0, ack1} !== ((exp_port == 0) ? 2'b10 : 2'b01)) begin
        fails++;
        $display("FAIL rr_ack%0d: got ack0=%b ack1=%b expected port %0d", k, ack0, ack1, exp_port);
      end
      if (k == 3) begin
        req0 = 0; req1 = 0;
      end
      tick();
      checks++;
      if (busy !== 1'b0) begin
        fails++;
        $display("FAIL rr_idle%0d: got busy=%b expected 0", k, busy);
      end
    end
    tick();
  endtask

  task automatic test_late_done();
    req0 = 1; we0 = 0;
    tick();
    tick();
    for (int i = 0; i < 15; i++) tick();
    checks++;
    if (ack0 !== 1'b0) begin
      fails++;
      $display("FAIL late_early_ack: got ack0=%b expected 0", ack0);
    end
    rx_done = 1; r_data = 8'hC3;
    tick();
    rx_done = 0; r_data = 8'h00;
    checks++;
    if ({ack0, err0, rdata0} !== {2'b10, 8'hC3}) begin
      fails++;
      $display("FAIL late_done: got ack0=%b err0=%b rdata0=%h expected 1 0 c3", ack0, err0, rdata0);
    end
    req0 = 0;
    tick();
  endtask

  task automatic test_timeout();
    int waits;
    waits = 0;
    req0 = 1; we0 = 0;
    tick();
    tick();
    while (ack0 !== 1'b1 && waits < 40) begin
      tick();
      waits++;
    end
    checks++;
    if (waits !== 16) begin
      fails++;
      $display("FAIL to_cycles: got %0d wait cycles expected 16", waits);
    end
    checks++;
    if ({ack0, err0, rdata0} !== {2'b11, 8'h00}) begin
      fails++;
      $display("FAIL to_resp: got ack0=%b err0=%b rdata0=%h expected 1 1 00", ack0, err0, rdata0);
    end
    req0 = 0;
    tick();
    checks++;
    if ({ack0, err0} !== 2'b00) begin
      fails++;
      $display("FAIL to_clear: got ack0=%b err0=%b expected 0 0", ack0, err0);
    end
  endtask

  task automatic test_reset_abort();
    int a0;
    req0 = 1; we0 = 1; wdata0 = 8'h77;
    tick(); tick(); tick();
    a0 = ack0_n;
    rstn = 0;
    #1;
    checks++;
    if ({ack0, ack1, err0, err1, t_valid, r_valid, busy, t_data} !== {7'b0, 8'h00}) begin
      fails++;
      $display("FAIL abort_outputs: got flags=%b t_data=%h expected 0000000 00",
               {ack0, ack1, err0, err1, t_valid, r_valid, busy}, t_data);
    end
    tx_done = 1;
    tick();
    tx_done = 0; req0 = 0;
    rstn = 1;
    tick(); tick(); tick();
    checks++;
    if ((ack0_n - a0) !== 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL abort_noack: got acks=%0d busy=%b expected 0 0", ack0_n - a0, busy);
    end
    req0 = 1; we0 = 1; wdata0 = 8'h10;
    req1 = 1; we1 = 1; wdata1 = 8'h20;
    tick();
    checks++;
    if ({t_valid, t_data} !== {1'b1, 8'h10}) begin
      fails++;
      $display("FAIL abort_tie: got tv=%b data=%h expected 1 10", t_valid, t_data);
    end
    tick();
    tx_done = 1;
    tick();
    tx_done = 0;
    checks++;
    if ({ack0, ack1} !== 2'b10) begin
      fails++;
      $display("FAIL abort_tie_ack: got ack0=%b ack1=%b expected 1 0", ack0, ack1);
    end
    req0 = 0; req1 = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_write_port0();
    test_read_port1();
    test_u_ready_gate();
    test_back_to_back();
    test_late_done();
    test_timeout();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
